// File: rtl/rom_arb_pkg.sv
// Shared constants for the graphics ROM port arbiter: default widths, requester IDs, tag width.
package rom_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 3;
  localparam int unsigned DEF_ADDR_W  = 12;
  localparam int unsigned DEF_DATA_W  = 8;

  localparam int unsigned REQ_MAP    = 0;
  localparam int unsigned REQ_TILE   = 1;
  localparam int unsigned REQ_SPRITE = 2;

  localparam int unsigned TAG_W = $clog2(DEF_NUM_REQ);

  // Keeps ID fields at least one bit wide when a single requester is configured.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// Delay line of {valid, requester id} tags that tracks reads in flight through the ROM.
module rom_arb_tag_pipe #(
  parameter int unsigned Depth = 1,
  parameter int unsigned IdW   = 2
) (
  input  logic           clk_i,
  input  logic           clear_ni,
  input  logic           valid_i,
  input  logic [IdW-1:0] id_i,
  output logic           valid_o,
  output logic [IdW-1:0] id_o,
  output logic           any_valid_o
);

  logic [Depth-1:0]          valid_q;
  logic [Depth-1:0][IdW-1:0] id_q;

  always_ff @(posedge clk_i) begin
    if (!clear_ni) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q[0] <= valid_i;
      id_q[0]    <= id_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign valid_o     = valid_q[Depth-1];
  assign id_o        = id_q[Depth-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous-read graphics ROM port between the map, tile and sprite drawers.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0] req_rot;
  logic [IdW-1:0]     base;
  logic [IdW-1:0]     off;
  logic [IdW:0]       sum;
  logic [IdW-1:0]     winner;
  logic               any_req;
  logic               found;

  logic [ADDR_W-1:0]  addr_q;
  logic [NUM_REQ-1:0] rd_valid_q;
  logic [DATA_W-1:0]  rd_data_q;

  logic               tail_valid;
  logic [IdW-1:0]     tail_id;
  logic               tags_busy;

  // No grants while reset is sampled, so nothing enters the tag pipe then.
  assign any_req = resetn & (|req);

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic [IdW-1:0]       rr_ptr_q;
  logic [IdW-1:0]       rr_ptr_d;
  logic [2*NUM_REQ-1:0] req_dbl;

  // Rotate requests so the pointer position lands on bit 0.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[rr_ptr_q +: NUM_REQ];
  assign base    = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_req) begin
      rr_ptr_d = (winner == IdW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign req_rot = req;
  assign base    = '0;
`endif

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        off   = IdW'(i);
        found = 1'b1;
      end
    end
  end

  // Undo the rotation: winner = (base + off) mod NUM_REQ.
  assign sum    = {1'b0, base} + {1'b0, off};
  assign winner = (sum >= (IdW+1)'(NUM_REQ)) ? IdW'(sum - (IdW+1)'(NUM_REQ)) : IdW'(sum);

  always_comb begin
    gnt         = '0;
    rom_address = addr_q;
    if (any_req) begin
      gnt         = NUM_REQ'(1) << winner;
      rom_address = addr[int'(winner)*ADDR_W +: ADDR_W];
    end
  end

  rom_arb_tag_pipe #(
    .Depth (ROM_LATENCY),
    .IdW   (IdW)
  ) u_tag_pipe (
    .clk_i       (clk),
    .clear_ni    (resetn),
    .valid_i     (any_req),
    .id_i        (winner),
    .valid_o     (tail_valid),
    .id_o        (tail_id),
    .any_valid_o (tags_busy)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q     <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      if (any_req) begin
        addr_q <= rom_address;
      end
      rd_valid_q <= tail_valid ? (NUM_REQ'(1) << tail_id) : '0;
      if (tail_valid) begin
        rd_data_q <= rom_q;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign busy     = (|req) | tags_busy;

endmodule
